// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache. Hits are served combinationally;
// a miss stalls the fetch port while one 16-byte block is refilled from memory.
module instruction_cache #(
    parameter int NBLOCKS = 8,
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [ADDR_W-1:0]   address,
    output logic [31:0]         instruction,
    output logic                busywait,
    output logic                imem_read,
    output logic [ADDR_W-5:0]   imem_address,
    input  logic [127:0]        imem_readdata,
    input  logic                imem_busywait,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    localparam int IDX_W = $clog2(NBLOCKS);
    localparam int TAG_W = ADDR_W - 4 - IDX_W;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MEM_READ = 2'd1;
    localparam logic [1:0] UPDATE   = 2'd2;

    logic [1:0]          state;
    logic [NBLOCKS-1:0]  validBits;
    logic [TAG_W-1:0]    tagArray  [NBLOCKS];
    logic [3:0][31:0]    dataArray [NBLOCKS];

    logic [TAG_W-1:0]    refillTag;
    logic [IDX_W-1:0]    refillIndex;
    logic [3:0][31:0]    refillBuf;
    logic [31:0]         lastInstr;

    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    index;
    logic [1:0]          offset;
    logic                hit;
    logic [31:0]         hitWord;
    logic [1:0]          unusedAddr;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign tag        = address[ADDR_W-1 -: TAG_W];
    assign index      = address[4 +: IDX_W];
    assign offset     = address[3:2];
    assign unusedAddr = address[1:0];

    assign hit     = (state == IDLE) && validBits[index] && (tagArray[index] == tag);
    assign hitWord = dataArray[index][offset];

    assign instruction  = hit ? hitWord : lastInstr;
    assign busywait     = RESET && !hit;
    assign imem_read    = (state == MEM_READ);
    assign imem_address = {refillTag, refillIndex};

    // Control state: everything the fetch port and counters can observe after reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            validBits   <= '0;
            refillTag   <= '0;
            refillIndex <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            lastInstr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        hit_count <= satInc(hit_count);
                        lastInstr <= hitWord;
                    end else begin
                        refillTag   <= tag;
                        refillIndex <= index;
                        miss_count  <= satInc(miss_count);
                        state       <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (!imem_busywait)
                        state <= UPDATE;
                end
                UPDATE: begin
                    validBits[refillIndex] <= 1'b1;
                    state                  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage only ever sees the latched refill index, so a wandering
    // address during a stall cannot touch any other line.
    always_ff @(posedge CLK) begin
        if (state == MEM_READ && !imem_busywait)
            refillBuf <= imem_readdata;
        if (state == UPDATE) begin
            dataArray[refillIndex] <= refillBuf;
            tagArray[refillIndex]  <= refillTag;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: a behavioural block memory with a
// programmable latency, a tag model for hit/miss prediction, and counter checks.
module tb_instruction_cache;

    logic         CLK;
    logic         RESET;
    logic [9:0]   address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         imem_read;
    logic [5:0]   imem_address;
    logic [127:0] imem_readdata;
    logic         imem_busywait;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    logic [31:0]  satInstr;
    logic         satBusy;
    logic         satRead;
    logic [5:0]   satAddr;
    logic [3:0]   satHit;
    logic [3:0]   satMiss;

    int           nAsserts = 0;
    int           nFails   = 0;
    int           memLat   = 5;
    int           memRem   = 0;
    bit           served   = 0;
    int           expHits  = 0;
    int           expMiss  = 0;
    bit           tbValid [8];
    logic [2:0]   tbTag   [8];
    logic [31:0]  expQ    [$];

    instruction_cache dut (
        .CLK(CLK), .RESET(RESET), .address(address), .instruction(instruction),
        .busywait(busywait), .imem_read(imem_read), .imem_address(imem_address),
        .imem_readdata(imem_readdata), .imem_busywait(imem_busywait),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    instruction_cache #(.CNT_W(4)) satDut (
        .CLK(CLK), .RESET(RESET), .address(address), .instruction(satInstr),
        .busywait(satBusy), .imem_read(satRead), .imem_address(satAddr),
        .imem_readdata(imem_readdata), .imem_busywait(imem_busywait),
        .hit_count(satHit), .miss_count(satMiss)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] memWord(input logic [9:0] a);
        return {16'hC0DE, 6'd0, a[9:2], 2'b00};
    endfunction

    always_comb begin
        imem_readdata = {memWord({imem_address, 4'hC}), memWord({imem_address, 4'h8}),
                         memWord({imem_address, 4'h4}), memWord({imem_address, 4'h0})};
    end

    // Memory keeps busywait high for memLat-1 edges, so MEM_READ lasts memLat cycles.
    always @(negedge CLK) begin
        if (memRem > 0) begin
            memRem = memRem - 1;
            if (memRem == 0) imem_busywait = 1'b0;
        end else if (imem_read && !served) begin
            served        = 1'b1;
            memRem        = memLat - 1;
            imem_busywait = (memLat > 1);
        end
        if (!imem_read) served = 1'b0;
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAsserts++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat15(input int v);
        return (v > 15) ? 32'd15 : 32'(v);
    endfunction

    task automatic checkCounters();
        checkEq("hitCount",  32'(hit_count),  32'(expHits));
        checkEq("missCount", 32'(miss_count), 32'(expMiss));
        checkEq("satHit",    32'(satHit),     sat15(expHits));
        checkEq("satMiss",   32'(satMiss),    sat15(expMiss));
    endtask

    // Entered and left at posedge+1; the final edge registers this access's hit.
    task automatic fetch(input logic [9:0] a);
        logic [2:0]  t;
        logic [2:0]  idx;
        logic [31:0] exp;
        bit          miss;
        bit          sawRead;
        int          stall;
        t       = a[9:7];
        idx     = a[6:4];
        miss    = !(tbValid[idx] && tbTag[idx] == t);
        address = a;
        expQ.push_back(memWord(a));
        #1;
        checkEq("busyOnAccess", 32'(busywait), 32'(miss));
        stall   = 0;
        sawRead = 0;
        while (busywait && stall < 200) begin
            @(posedge CLK);
            #1;
            stall++;
            if (imem_read) begin
                sawRead = 1;
                checkEq("imemAddr", 32'(imem_address), 32'(a[9:4]));
            end
        end
        if (busywait) checkEq("stallTimeout", 32'(busywait), 32'd0);
        if (miss) expMiss++;
        checkEq("stallCycles", 32'(stall), miss ? 32'(memLat + 2) : 32'd0);
        checkEq("imemRead", 32'(sawRead), 32'(miss));
        exp = expQ.pop_front();
        checkEq("instr", instruction, exp);
        checkCounters();
        tbValid[idx] = 1'b1;
        tbTag[idx]   = t;
        @(posedge CLK);
        #1;
        expHits++;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 8; i++) tbValid[i] = 1'b0;
        expHits = 0;
        expMiss = 0;
    endtask

    initial begin
        RESET         = 1'b1;
        address       = 10'h000;
        imem_busywait = 1'b0;
        clearModel();
        #3 RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkEq("rstBusy",     32'(busywait),     32'd0);
        checkEq("rstRead",     32'(imem_read),    32'd0);
        checkEq("rstImemAddr", 32'(imem_address), 32'd0);
        checkEq("rstInstr",    instruction,       32'd0);
        checkCounters();

        RESET = 1'b1;
        fetch(10'h000);
        fetch(10'h004);
        fetch(10'h008);
        fetch(10'h00C);

        memLat = 2;
        fetch(10'h080);
        fetch(10'h000);
        fetch(10'h010);
        fetch(10'h3F0);
        fetch(10'h014);
        fetch(10'h3FC);
        fetch(10'h008);

        memLat  = 5;
        address = 10'h040;
        repeat (3) @(posedge CLK);
        #1;
        checkEq("midRefillRead", 32'(imem_read), 32'd1);
        #2 RESET = 1'b0;
        #1;
        checkEq("abortRead",     32'(imem_read),    32'd0);
        checkEq("abortBusy",     32'(busywait),     32'd0);
        checkEq("abortImemAddr", 32'(imem_address), 32'd0);
        checkEq("abortInstr",    instruction,       32'd0);
        clearModel();
        checkCounters();
        repeat (8) @(posedge CLK);
        #1;
        RESET = 1'b1;
        fetch(10'h040);
        for (int i = 0; i < 20; i++) fetch(10'h040 + 10'(4 * (i % 4)));

        repeat (3) @(posedge CLK);
        #1;
        checkEq("satHold",    32'(satHit),    32'd15);
        checkEq("hitRunning", 32'(hit_count), 32'(expHits + 3));

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
